serial_adder: RTL and testbench

Multi-cycle, parametrised adder that generalises the single-bit full adder to a WIDTH-bit operation. It processes DIGIT bits per clock through a registered carry chain, using a start/busy/done handshake. The block sits beside the combinational full adder as the area-saving arithmetic option for wide datapaths where latency is acceptable. Results are held stable between operations.

---
 rtl/serial_adder.sv | 153 +++++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder that retires DIGIT bits per clock.
// The carry between digits is held in a register rather than rippled through.
// Build option: define SERIAL_ADDER_SUB_EN to add the sub port, which selects
// a - b - c (computed as a + ~b + !c).

// Single-bit full adder; DIGIT copies of it form the per-cycle carry chain.
module fa_lane (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Operands as captured on an accepted start, already in add form.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t           state, state_nxt;
    req_t             req;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             inv;
    logic             accept, step, last;
    logic [DIGIT:0]   ch;
    logic [DIGIT-1:0] dsum;

`ifdef SERIAL_ADDER_SUB_EN
    assign inv = sub;
`else
    assign inv = 1'b0;
`endif

    assign last = (cnt == CW'(N - 1));

    // Per-digit carry chain fed by the carry register.
    assign ch[0] = cy;
    for (genvar i = 0; i < DIGIT; i++) begin : g_lane
        fa_lane u_fa (
            .a  (req.a[i]),
            .b  (req.b[i]),
            .ci (ch[i]),
            .s  (dsum[i]),
            .co (ch[i+1])
        );
    end

    // New digit enters at the top; after N steps the LSB digit sits at bit 0.
    if (DIGIT == WIDTH) begin : g_acc_one
        assign acc_nxt = dsum;
    end else begin : g_acc_shift
        assign acc_nxt = {dsum, acc[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; start is only looked at outside RUN.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, shift one digit per step, publish results on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req   <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            req.a <= a;
            req.b <= inv ? ~b : b;
            cy    <= inv ? ~c : c;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            req.a <= req.a >> DIGIT;
            req.b <= req.b >> DIGIT;
            acc   <= acc_nxt;
            cy    <= ch[DIGIT];
            cnt   <= cnt + 1'b1;
            if (last) begin
                sum   <= acc_nxt;
                carry <= ch[DIGIT];
                // On the last step the top lane is bit WIDTH-1.
                ovf   <= ch[DIGIT] ^ ch[DIGIT-1];
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT = 1, 4, 8 at WIDTH = 8)
// driven from a vector table plus hand sequences for handshake corner cases.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [2:0] c = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic [2:0] sub = '0;
`endif
    logic [2:0] busy, done, carry, ovf;
    logic [7:0] sum [3];

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]), .c(c[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[0]),
`endif
        .busy(busy[0]), .done(done[0]), .sum(sum[0]), .carry(carry[0]), .ovf(ovf[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1]), .b(b[1]), .c(c[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[1]),
`endif
        .busy(busy[1]), .done(done[1]), .sum(sum[1]), .carry(carry[1]), .ovf(ovf[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a[2]), .b(b[2]), .c(c[2]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[2]),
`endif
        .busy(busy[2]), .done(done[2]), .sum(sum[2]), .carry(carry[2]), .ovf(ovf[2]));

    typedef struct {
        int         k;
        logic [7:0] a, b;
        logic       c, sb;
        logic [7:0] es;
        logic       ec, eo;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int nsteps(input int k);
        return (k == 0) ? 8 : (k == 1) ? 2 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on instance k; operands are scrambled right after the
    // accepting edge to prove they were captured. Returns cycles to done.
    task automatic do_op(input int k, input logic [7:0] aa, input logic [7:0] bb,
                         input logic cc, input logic ss, output int lat);
        a[k] = aa; b[k] = bb; c[k] = cc;
`ifdef SERIAL_ADDER_SUB_EN
        sub[k] = ss;
`else
        if (ss) $display("note: subtract vector skipped in add-only build");
`endif
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        a[k] = ~aa; b[k] = 8'h5A; c[k] = ~cc;
        chk($sformatf("busy_after_start k%0d", k), 32'(busy[k]), 32'd1);
        lat = 0;
        while (!done[k] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, t1, t2, ndone, cyc;
        logic [7:0] s_exp;

        for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end

        // Vector table.
        tbl.push_back('{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
        tbl.push_back('{0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h5A, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        for (int m = 0; m < 8; m++) begin
            s_exp = 8'(m[2] + m[1] + m[0]);
            tbl.push_back('{1, {7'd0, m[2]}, {7'd0, m[1]}, m[0], 1'b0, s_exp, 1'b0, 1'b0});
        end
        tbl.push_back('{2, 8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1});
        tbl.push_back('{2, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        tbl.push_back('{0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        tbl.push_back('{0, 8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0});
`endif

        // Reset state.
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy k%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_done k%0d", k), 32'(done[k]), 32'd0);
            chk($sformatf("rst_sum k%0d", k), 32'(sum[k]), 32'd0);
            chk($sformatf("rst_flags k%0d", k), {30'd0, carry[k], ovf[k]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            do_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sb, lat);
            chk($sformatf("latency v%0d", i), 32'(lat), 32'(nsteps(tbl[i].k)));
            chk($sformatf("sum v%0d", i), 32'(sum[tbl[i].k]), 32'(tbl[i].es));
            chk($sformatf("carry v%0d", i), 32'(carry[tbl[i].k]), 32'(tbl[i].ec));
            chk($sformatf("ovf v%0d", i), 32'(ovf[tbl[i].k]), 32'(tbl[i].eo));
            chk($sformatf("busy_in_done v%0d", i), 32'(busy[tbl[i].k]), 32'd0);
            tick();
            chk($sformatf("done_one_cycle v%0d", i), 32'(done[tbl[i].k]), 32'd0);
            chk($sformatf("sum_held v%0d", i), 32'(sum[tbl[i].k]), 32'(tbl[i].es));
        end

        // Start re-pulsed during RUN is ignored and not queued.
        a[0] = 8'h11; b[0] = 8'h22; c[0] = 1'b0; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick(); tick();
        a[0] = 8'hFF; b[0] = 8'hFF; c[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("sum_not_leaked_in_run", 32'(sum[0]), 32'h46);
        lat = 0;
        while (!done[0] && lat < 40) begin tick(); lat++; end
        chk("repulse_latency", 32'(lat), 32'd5);
        chk("repulse_sum", 32'(sum[0]), 32'h33);
        chk("repulse_carry", 32'(carry[0]), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done[0] || busy[0]) ndone++;
        end
        chk("repulse_not_queued", 32'(ndone), 32'd0);

        // Start held high: results every N+1 cycles.
        a[0] = 8'h01; b[0] = 8'h02; c[0] = 1'b0; start[0] = 1'b1;
        cyc = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && cyc < 60) begin
            tick();
            cyc++;
            if (done[0]) begin
                if (t1 < 0) t1 = cyc; else t2 = cyc;
            end
        end
        start[0] = 1'b0;
        chk("b2b_first", 32'(t1), 32'd9);
        chk("b2b_spacing", 32'(t2 - t1), 32'd9);
        chk("b2b_sum", 32'(sum[0]), 32'h03);

        // Reset at step 3 of an 8-step run.
        tick();
        a[0] = 8'hF0; b[0] = 8'h0F; c[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick(); tick(); tick();
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_done", 32'(done[0]), 32'd0);
        chk("midrst_sum", 32'(sum[0]), 32'd0);
        chk("midrst_flags", {30'd0, carry[0], ovf[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done[0] || busy[0]) ndone++;
        end
        chk("no_done_after_reset", 32'(ndone), 32'd0);
        do_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, lat);
        chk("post_reset_latency", 32'(lat), 32'd8);
        chk("post_reset_sum", 32'(sum[0]), 32'h10);
        chk("post_reset_carry", 32'(carry[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
